// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Purpose  : ROM fetch port, datapath strobes and run status of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
    logic       start;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic       acc_we;
    logic       alu_op;
    logic       busy;
    logic       done;
    logic       illegal_op;

    modport master (
        input  start, rom_data,
        output rom_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               acc_we, alu_op, busy, done, illegal_op
    );

    modport slave (
        output start, rom_data,
        input  rom_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               acc_we, alu_op, busy, done, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Fetch/decode/execute controller driving ROM address and datapath
//            write strobes for the 4-bit processor.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter logic [3:0] START_ADDR = 4'h1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    instr_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] c_op_add = 4'h0;
    localparam logic [3:0] c_op_sub = 4'h1;
    localparam logic [3:0] c_op_mov = 4'h4;
    localparam logic [3:0] c_pc_max = 4'hF;

    state_t     r_state;
    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic       r_rf_we;
    logic       r_acc_we;
    logic       r_alu_op;
    logic       r_illegal;
    logic       r_busy;
    logic       r_done;

    logic       w_is_add;
    logic       w_is_sub;
    logic       w_is_mov;

    assign w_is_add = (r_ir[7:4] == c_op_add);
    assign w_is_sub = (r_ir[7:4] == c_op_sub);
    assign w_is_mov = (r_ir[7:4] == c_op_mov);

    // Operand fields come from IR only, so nothing here follows rom_data.
    assign bus.rom_addr   = r_pc;
    assign bus.rf_raddr_a = r_ir[3:2];
    assign bus.rf_raddr_b = r_ir[1:0];
    assign bus.rf_waddr   = r_ir[3:2];
    assign bus.rf_wdata   = {2'b00, r_ir[1:0]};
    assign bus.rf_we      = r_rf_we;
    assign bus.acc_we     = r_acc_we;
    assign bus.alu_op     = r_alu_op;
    assign bus.illegal_op = r_illegal;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= START_ADDR;
            r_ir      <= 8'h00;
            r_rf_we   <= 1'b0;
            r_acc_we  <= 1'b0;
            r_alu_op  <= 1'b0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_pc    <= START_ADDR;
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_ir    <= bus.rom_data;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (r_ir == 8'h00) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        // Strobes are registered here so they sit exactly in EXEC.
                        r_state   <= S_EXEC;
                        r_rf_we   <= w_is_mov;
                        r_acc_we  <= w_is_add | w_is_sub;
                        r_alu_op  <= (w_is_add | w_is_sub) & r_ir[4];
                        r_illegal <= ~(w_is_add | w_is_sub | w_is_mov);
                    end
                end
                S_EXEC: begin
                    r_rf_we   <= 1'b0;
                    r_acc_we  <= 1'b0;
                    r_alu_op  <= 1'b0;
                    r_illegal <= 1'b0;
                    if (r_pc == c_pc_max) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + 4'd1;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer against a program-level
//            model of the fetch/decode/execute timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    typedef struct {
        int         cyc;
        logic       rf_we;
        logic       acc_we;
        logic       alu_op;
        logic       ill;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] waddr;
        logic [3:0] wdata;
    } ev_t;

    typedef struct {
        logic [7:0] instr;
        logic       rf_we;
        logic       acc_we;
        logic       alu_op;
        logic       ill;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [3:0] wdata;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rom [16];

    int         n_checks;
    int         n_fail;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    int         got_done;
    int         exp_done;
    logic [3:0] exp_pc;

    instr_sequencer_if bus ();

    assign bus.rom_data = rom[bus.rom_addr];

    instr_sequencer #(.START_ADDR(4'h1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input ev_t e);
        logic [7:0] c;
        c = e.cyc[7:0];
        return {10'd0, c, e.rf_we, e.acc_we, e.alu_op, e.ill, e.ra, e.rb, e.waddr, e.wdata};
    endfunction

    // Walks the ROM as a program: slot n fetches at +3(n-1), executes at +3n-1.
    task automatic model();
        int   pc;
        ev_t  e;
        logic [7:0] ins;
        logic [3:0] op;
        exp_q.delete();
        pc = 1;
        exp_done = -2;
        exp_pc = 4'h1;
        for (int n = 1; n <= 16; n++) begin
            ins = rom[pc];
            if (ins == 8'h00) begin
                exp_done = 3 * (n - 1) + 2;
                exp_pc   = pc[3:0];
                return;
            end
            op       = ins[7:4];
            e.cyc    = 3 * n - 1;
            e.rf_we  = (op == 4'd4);
            e.acc_we = (op == 4'd0) || (op == 4'd1);
            e.alu_op = (op == 4'd1);
            e.ill    = !(e.rf_we || e.acc_we);
            e.ra     = ins[3:2];
            e.rb     = ins[1:0];
            e.waddr  = ins[3:2];
            e.wdata  = {2'b00, ins[1:0]};
            exp_q.push_back(e);
            if (pc == 15) begin
                exp_done = 3 * n;
                exp_pc   = 4'hF;
                return;
            end
            pc++;
        end
    endtask

    // Runs one program from a start pulse; inj>0 adds a second start pulse
    // sampled at the edge ending cycle inj.
    task automatic run_program(input string name, input int inj);
        ev_t e;
        int  nmin;
        model();
        got_q.delete();
        got_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (j == 0) bus.start = 1'b0;
            if (j == inj) bus.start = 1'b1;
            else if (j == inj + 1) bus.start = 1'b0;
            if (bus.rf_we || bus.acc_we || bus.illegal_op) begin
                e.cyc    = j;
                e.rf_we  = bus.rf_we;
                e.acc_we = bus.acc_we;
                e.alu_op = bus.alu_op;
                e.ill    = bus.illegal_op;
                e.ra     = bus.rf_raddr_a;
                e.rb     = bus.rf_raddr_b;
                e.waddr  = bus.rf_waddr;
                e.wdata  = bus.rf_wdata;
                got_q.push_back(e);
            end
            if (bus.done && got_done < 0) got_done = j;
            if (got_done >= 0 && j >= got_done + 3) break;
        end
        bus.start = 1'b0;
        check({name, ".done_cycle"}, got_done, exp_done);
        check({name, ".n_events"}, got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            check($sformatf("%s.event%0d", name, i), pack(got_q[i]), pack(exp_q[i]));
        check({name, ".final"}, {27'd0, bus.busy, bus.done, bus.rom_addr},
              {27'd0, 1'b0, 1'b1, exp_pc});
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {20'd0, bus.rf_we, bus.acc_we, bus.alu_op, bus.illegal_op,
                     bus.busy, bus.done, bus.rom_addr, bus.rf_raddr_a},
              {20'd0, 6'b000000, 4'h1, 2'd0});
    endtask

    task automatic load_default();
        logic [7:0] prog [7];
        prog = '{8'h46, 8'h4B, 8'h06, 8'h4D, 8'h43, 8'h13, 8'h00};
        for (int a = 0; a < 16; a++) rom[a] = 8'h00;
        for (int a = 0; a < 7; a++) rom[a + 1] = prog[a];
    endtask

    vec_t vecs [7];

    initial begin
        int rf_cnt;
        int acc_cnt;
        logic [3:0] ops [10];

        vecs[0] = '{8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 4'd2};
        vecs[1] = '{8'h13, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 4'd3};
        vecs[2] = '{8'h46, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 4'd2};
        vecs[3] = '{8'h4B, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 4'd3};
        vecs[4] = '{8'h25, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 4'd1};
        vecs[5] = '{8'hF3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 4'd3};
        vecs[6] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 4'd0};

        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        for (int a = 0; a < 16; a++) rom[a] = 8'h00;
        rst_n = 1'b0;
        #22;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-instruction programs followed by HALT.
        for (int v = 0; v < 7; v++) begin
            for (int a = 0; a < 16; a++) rom[a] = 8'h00;
            rom[1] = vecs[v].instr;
            run_program($sformatf("vec%0d", v), -10);
            check($sformatf("vec%0d.done_at_5", v), got_done, 5);
            if (got_q.size() == 1) begin
                check($sformatf("vec%0d.strobes", v),
                      {16'd0, got_q[0].cyc[3:0], got_q[0].rf_we, got_q[0].acc_we,
                       got_q[0].alu_op, got_q[0].ill, got_q[0].ra, got_q[0].rb,
                       got_q[0].waddr, got_q[0].wdata},
                      {16'd0, 4'd2, vecs[v].rf_we, vecs[v].acc_we,
                       vecs[v].alu_op, vecs[v].ill, vecs[v].ra, vecs[v].rb,
                       vecs[v].ra, vecs[v].wdata});
            end else begin
                check($sformatf("vec%0d.one_event", v), got_q.size(), 1);
            end
        end

        // Default program.
        load_default();
        run_program("default", -10);
        rf_cnt  = 0;
        acc_cnt = 0;
        foreach (got_q[i]) begin
            if (got_q[i].rf_we)  rf_cnt++;
            if (got_q[i].acc_we) acc_cnt++;
        end
        check("default.rf_we_count", rf_cnt, 4);
        check("default.acc_we_count", acc_cnt, 2);
        check("default.done_at_20", got_done, 20);

        // Reset during the third EXEC (ADD R1,R2 -> acc_we high).
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            if (j == 0) bus.start = 1'b0;
        end
        check("midrst.exec_before", {31'd0, bus.acc_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst.async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        run_program("midrst.rerun", -10);

        // No PC wrap: every slot is a MOV.
        for (int a = 0; a < 16; a++) rom[a] = 8'h47;
        run_program("nowrap", -10);
        check("nowrap.rf_we_count", got_q.size(), 15);
        check("nowrap.done_at_45", got_done, 45);
        check("nowrap.pc_held", {28'd0, bus.rom_addr}, 32'hF);

        // Start during DECODE is ignored; a restart from DONE repeats the trace.
        load_default();
        run_program("busystart", 1);
        run_program("busystart.rerun", -10);

        // Start coincident with DECODE->DONE (HALT in slot 1) is ignored.
        for (int a = 0; a < 16; a++) rom[a] = 8'h00;
        run_program("halt_start", 1);
        check("halt_start.done_at_2", got_done, 2);

        // Randomized programs.
        ops = '{4'h0, 4'h1, 4'h4, 4'h4, 4'h0, 4'h1, 4'h2, 4'h9, 4'h4, 4'hF};
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 16; a++) begin
                if ($urandom_range(0, 11) == 0) rom[a] = 8'h00;
                else rom[a] = {ops[$urandom_range(0, 9)], 4'($urandom_range(0, 15))};
            end
            run_program($sformatf("rand%0d", it), (it % 3 == 0) ? 4 : -10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
